// File: rtl/univ_shift_register.sv
// Universal N-bit shift register with single-step and burst operation.
// Modes cover hold, logical shifts, rotates, arithmetic shift right and
// parallel load. A burst shifts or rotates `count` times on its own and
// signals completion through the busy/done handshake.
module univ_shift_register #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             so_msb,
  output logic             so_lsb,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] ModeHold = 3'b000;
  localparam logic [2:0] ModeShl  = 3'b001;
  localparam logic [2:0] ModeShr  = 3'b010;
  localparam logic [2:0] ModeRotl = 3'b011;
  localparam logic [2:0] ModeRotr = 3'b100;
  localparam logic [2:0] ModeAshr = 3'b101;
  localparam logic [2:0] ModeLoad = 3'b110;

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] rem_q;
  logic [2:0]       op_q;
  logic             busy_q;
  logic             done_q;

  // Next register value for one application of `op`.
  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] cur,
                                                input logic             sr,
                                                input logic             sl,
                                                input logic [WIDTH-1:0] ld);
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    case (op)
      ModeShl:  nxt = {cur[WIDTH-2:0], sr};
      ModeShr:  nxt = {sl, cur[WIDTH-1:1]};
      ModeRotl: nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      ModeRotr: nxt = {cur[0], cur[WIDTH-1:1]};
      ModeAshr: nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      ModeLoad: nxt = ld;
      default:  nxt = cur;  // hold and reserved
    endcase
    return nxt;
  endfunction

  // Only shifts and rotates may run as a burst.
  logic burst_mode;
  assign burst_mode = (mode != ModeHold) && (mode != ModeLoad) && (mode != 3'b111);

  // Two-state burst FSM with registered busy/done and the data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      rem_q   <= '0;
      op_q    <= ModeHold;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && burst_mode && (count != '0)) begin
            // Accept cycle only latches the command; shifting starts next edge.
            op_q    <= mode;
            rem_q   <= count;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else if (start && burst_mode) begin
            done_q <= 1'b1;
          end else if (en) begin
            data_q <= apply_op(mode, data_q, sin_r, sin_l, d);
          end
        end
        StRun: begin
          // Serial inputs are sampled live so a stream can be clocked in.
          data_q <= apply_op(op_q, data_q, sin_r, sin_l, d);
          rem_q  <= rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign q      = data_q;
  assign so_msb = data_q[WIDTH-1];
  assign so_lsb = data_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: doc/univ_shift_register.md
Name: univ_shift_register

Overview:
- Parametrised universal shift register: N-bit, eight-way mode select covering hold, logical shifts, rotates, arithmetic shift right and parallel load.
- Adds a burst engine: a `start` command shifts or rotates a programmed number of times autonomously, with `busy`/`done` handshake.
- Successor to the fixed 4-bit bidirectional serial shifter.
- Used as a serialiser/deserialiser front end and as a barrel-shift substitute in slow datapaths.

Parameters:
- WIDTH, 8, register width in bits; must be >= 2.
- CNT_W, $clog2(WIDTH)+1, width of burst count; max burst length is 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- mode  input  3  op select:
  - 000 hold
  - 001 shl
  - 010 shr
  - 011 rotl
  - 100 rotr
  - 101 ashr
  - 110 load
  - 111 reserved (acts as hold)
- en  input  1  single-step enable; applies `mode` once per cycle while idle.
- start  input  1  burst request, sampled while idle.
- count  input  CNT_W  burst length, sampled with `start`.
- sin_r  input  1  serial in; enters q[0] on shl.
- sin_l  input  1  serial in; enters q[WIDTH-1] on shr.
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents; q[0] is LSB.
- so_msb  output  1  = q[WIDTH-1] (combinational); bit lost on next shl.
- so_lsb  output  1  = q[0] (combinational); bit lost on next shr/ashr.
- busy  output  1  registered; high while a burst is running.
- done  output  1  registered; one-cycle pulse after a burst ends.

Behaviour:
- Reset: synchronous, active-high, dominates every input.
  - q=0, state=IDLE, remaining count=0, busy=0, done=0.
  - Reset mid-burst aborts the burst with no done pulse.
- Operations (next q):
  - shl: {q[W-2:0], sin_r}
  - shr: {sin_l, q[W-1:1]}
  - rotl: {q[W-2:0], q[W-1]}
  - rotr: {q[0], q[W-1:1]}
  - ashr: {q[W-1], q[W-1:1]}
  - load: d
  - hold/reserved: q
- FSM has two states, IDLE and RUN.
- IDLE, priority order:
  1. start=1 with mode in 001..101 and count!=0:
     - at the edge, latch the op and rem<=count, go to RUN.
     - No shift in the accept cycle; busy=1 from the next cycle.
  2. start=1 with count=0 and a shift/rotate mode: no shift; done=1 for the next cycle; stay IDLE.
  3. start=1 with mode 000, 110 or 111: start is ignored, then the en rule applies.
  4. en=1: apply `mode` once; done stays 0.
  5. Otherwise: hold.
- RUN:
  - Each edge applies the latched op and sets rem<=rem-1.
  - sin_l/sin_r are sampled live every cycle, so a serial stream can be clocked in.
  - When rem==1 at an edge: final shift, state<=IDLE, done<=1.
  - Net effect: busy is high for exactly `count` cycles, and the register performs exactly `count` operations.
  - done rises in the cycle busy falls and lasts one cycle.
  - en, start, mode, count and d are ignored while in RUN.
- Back-to-back bursts: start may be asserted in the done cycle; it is accepted normally, so busy rises again one cycle later.
- count > WIDTH is legal; rotates wrap modulo WIDTH.
- done never asserts outside a burst completion or a count=0 start.

Test Plan:
- rst=1 with q loaded to 0xA5 -> q=0x00, busy=0, done=0 on the next edge.
- mode=110 en=1 d=0x96; then mode=001 en=1 sin_r=1 -> q=0x96 then 0x2D; before the shift so_msb=1.
- load 0x81; start mode=011 (rotl) count=3 -> busy high exactly 3 cycles, q=0x0C, done pulses once as busy falls.
- load 0x90; start mode=101 (ashr) count=2 -> q=0xE4; then count=9 (> WIDTH) rotr from 0x01 -> q=0x80.
- start with count=0 -> q unchanged, done pulse next cycle, busy stays 0.
- start mode=010 count=5 with sin_l=1; assert rst after 2 shifts -> q=0x00, busy=0, no done pulse.
- start during RUN with en=1 mode=110 -> ignored; q matches the latched-op-only model.
